// File: rtl/network_conv_accum_requant_if.sv
// Purpose: stream bundle between the conv product multiplier, the accumulate/requant block and its consumer.
// Latency: wires only, no state.
// Backpressure: in_ready stalls the product stream (it also drives multiplier ce); out_ready stalls the activation stream.
//
// Signals
//   in_valid  : in_prod valid (in_bias also valid on tap 0)
//   in_ready  : block accepts a product this cycle
//   in_prod   : signed product, PROD_W bits
//   in_bias   : signed per-channel bias, BIAS_W bits, sampled on tap 0 only
//   out_valid : out_data holds a valid activation
//   out_ready : downstream accepts out_data
//   out_data  : signed requantized activation, OUT_W bits
// Modports
//   master : product source / activation sink side
//   slave  : the accumulate/requant block
interface network_conv_accum_requant_if #(
    parameter int PROD_W = 28,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic [BIAS_W-1:0] in_bias;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_prod,
        output in_bias,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_bias,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/network_conv_accum_requant.sv
// Purpose: accumulates TAPS signed products plus a per-channel bias, then rounds, shifts, optionally ReLUs and saturates to OUT_W.
// Latency: last-tap transfer in cycle T gives out_valid in cycle T+2; one output per TAPS+2 cycles when unstalled.
// Backpressure: in_ready is low while an output is being formed or held; the held output waits for out_ready without loss.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous reset, active-low
//   bus      : slave side of the product/activation stream bundle
//   sat_flag : sticky, set when any output saturated; cleared only by reset
module network_conv_accum_requant #(
    parameter int PROD_W = 28,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 36,
    parameter int OUT_W  = 16,
    parameter int TAPS   = 9,
    parameter int SHIFT  = 12,
    parameter bit RELU   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    network_conv_accum_requant_if.slave  bus,
    output logic                         sat_flag
);

    localparam int TAP_W     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CLOG_TAPS = $clog2(TAPS);

    localparam logic [1:0] S_ACC  = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Half an output LSB at accumulator scale, for round-half-up.
    localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    // Output range expressed one bit wider than the accumulator so the
    // rounding add and the clamp comparisons can never overflow.
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Parameter sanity, caught at elaboration.
    if (ACC_W < PROD_W + CLOG_TAPS + 2) begin : g_chk_acc
        $error("ACC_W too narrow for PROD_W and TAPS");
    end
    if (ACC_W < BIAS_W + SHIFT + 1) begin : g_chk_bias
        $error("ACC_W too narrow for the shifted bias");
    end
    if (TAPS < 1 || TAPS > 256) begin : g_chk_taps
        $error("TAPS out of range 1..256");
    end
    if (SHIFT < 1 || SHIFT > ACC_W - OUT_W) begin : g_chk_shift
        $error("SHIFT out of range 1..ACC_W-OUT_W");
    end

    logic [1:0]              state;
    logic [TAP_W-1:0]        tap_cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;

    logic                    in_ready;
    logic                    xfer;
    logic                    tap_first;
    logic                    tap_last;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_sh;

    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   shr;
    logic signed [ACC_W:0]   clip;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        req_dat;

    assign in_ready      = (state == S_ACC);
    assign xfer          = bus.in_valid & in_ready;
    assign tap_first     = (tap_cnt == '0);
    assign tap_last      = (tap_cnt == TAP_W'(TAPS - 1));

    assign prod_ext = {{(ACC_W - PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    // Bias is in output LSBs, so lift it to product scale before adding.
    assign bias_sh  = {{(ACC_W - BIAS_W){bus.in_bias[BIAS_W-1]}}, bus.in_bias} << SHIFT;

    // Requantization of the finished sum.
    always_comb begin
        rnd_sum = {acc[ACC_W-1], acc} + RND;
        shr     = rnd_sum >>> SHIFT;
        clip    = (RELU && shr[ACC_W]) ? '0 : shr;
        sat_hi  = (clip > OUT_MAX);
        sat_lo  = (clip < OUT_MIN);
        if (sat_hi) begin
            req_dat = OUT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            req_dat = OUT_MIN[OUT_W-1:0];
        end else begin
            req_dat = clip[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_ACC;
            tap_cnt     <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag    <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (xfer) begin
                        // Tap 0 restarts the sum from the bias, so no separate clear is needed.
                        if (tap_first) begin
                            acc <= bias_sh + prod_ext;
                        end else begin
                            acc <= acc + prod_ext;
                        end
                        if (tap_last) begin
                            tap_cnt <= '0;
                            state   <= S_REQ;
                        end else begin
                            tap_cnt <= tap_cnt + TAP_W'(1);
                        end
                    end
                end
                S_REQ: begin
                    out_data_q  <= req_dat;
                    out_valid_q <= 1'b1;
                    if (sat_hi || sat_lo) begin
                        sat_flag <= 1'b1;
                    end
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    // out_valid is always high here, so out_ready alone completes the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_ACC;
                    end
                end
                default: begin
                    state <= S_ACC;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_network_conv_accum_requant.sv
// Purpose: directed and seeded-random checks of the accumulate/requant block, ReLU and signed builds side by side.
// Latency: checks last-tap to out_valid distance and output hold under stalled out_ready.
// Backpressure: holds out_ready low and presents in_valid while in_ready is low to show nothing is lost or doubled.
module tb_network_conv_accum_requant;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic out_ready;
    logic signed [27:0] in_prod;
    logic signed [15:0] in_bias;
    logic sat_r;
    logic sat_s;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [27:0] kp [9];

    always #5 clk = ~clk;

    network_conv_accum_requant_if #(.PROD_W(28), .BIAS_W(16), .OUT_W(16)) if_r ();
    network_conv_accum_requant_if #(.PROD_W(28), .BIAS_W(16), .OUT_W(16)) if_s ();

    assign if_r.in_valid  = in_valid;
    assign if_r.in_prod   = in_prod;
    assign if_r.in_bias   = in_bias;
    assign if_r.out_ready = out_ready;
    assign if_s.in_valid  = in_valid;
    assign if_s.in_prod   = in_prod;
    assign if_s.in_bias   = in_bias;
    assign if_s.out_ready = out_ready;

    network_conv_accum_requant #(.RELU(1'b1)) dut_r (
        .clk      (clk),
        .reset    (reset),
        .bus      (if_r),
        .sat_flag (sat_r)
    );

    network_conv_accum_requant #(.RELU(1'b0)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .bus      (if_s),
        .sat_flag (sat_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: round half up, arithmetic shift by 12, optional ReLU, clamp to 16 bits.
    function automatic logic [15:0] model(input longint acc, input bit relu, output bit sat);
        longint r;
        r   = (acc + 64'sd2048) >>> 12;
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        return r[15:0];
    endfunction

    function automatic longint kernel_acc(input logic signed [15:0] bias);
        longint a;
        a = longint'(bias) * 4096;
        for (int t = 0; t < 9; t++) a += longint'(kp[t]);
        return a;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!if_r.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!if_r.in_ready) check("in_ready_timeout", 64'(if_r.in_ready), 64'd1);
    endtask

    // Feeds kp[0..8]; random idle gaps up to max_gap with garbage on the data lines.
    task automatic feed(input logic signed [15:0] bias, input int max_gap);
        int gap;
        for (int t = 0; t < 9; t++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_prod  = 28'($urandom);
                in_bias  = 16'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_prod  = kp[t];
            in_bias  = (t == 0) ? bias : 16'($urandom);
            wait_ready();
            step();
        end
        in_valid = 1'b0;
        in_prod  = 28'($urandom);
    endtask

    // Waits for out_valid, compares both builds, then stalls for 'stall' cycles before accepting.
    task automatic collect(input string tag, input logic [15:0] exp_r, input logic [15:0] exp_s,
                           input int stall, output int lat);
        lat = 0;
        out_ready = (stall == 0);
        while (!if_r.out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!if_r.out_valid) check({tag, "_timeout"}, 64'(if_r.out_valid), 64'd1);
        check({tag, "_relu"}, 64'(if_r.out_data), 64'(exp_r));
        check({tag, "_sgn"},  64'(if_s.out_data), 64'(exp_s));
        for (int i = 0; i < stall; i++) step();
        out_ready = 1'b1;
        step();
    endtask

    task automatic fill(input logic signed [27:0] v);
        for (int t = 0; t < 9; t++) kp[t] = v;
    endtask

    initial begin
        int lat;
        bit sr;
        bit ss;
        longint a;
        logic [15:0] er;
        logic [15:0] es;
        logic signed [15:0] b;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_prod   = '0;
        in_bias   = '0;
        #12;
        check("rst_in_ready", 64'(if_r.in_ready), 64'd1);
        check("rst_out_valid", 64'(if_r.out_valid), 64'd0);
        check("rst_out_data", 64'(if_s.out_data), 64'd0);
        check("rst_sat", 64'({sat_r, sat_s}), 64'd0);
        step();
        reset = 1'b1;
        step();

        // 9 x 4096, no bias: 9.5 rounds up only at exactly .5 of 36864+2048 -> 9; out_valid two cycles after the last tap.
        fill(28'sd4096);
        feed(16'sd0, 0);
        check("lat_not_early", 64'(if_r.out_valid), 64'd0);
        collect("t1", 16'd9, 16'd9, 0, lat);
        check("lat_t1", 64'(lat), 64'd1);

        // Rounding boundary: 2048 rounds to 1, 2047 rounds to 0.
        fill(28'sd0); kp[0] = 28'sd2048;
        feed(16'sd0, 0);
        collect("rnd_up", 16'd1, 16'd1, 0, lat);
        kp[0] = 28'sd2047;
        feed(16'sd0, 0);
        collect("rnd_dn", 16'd0, 16'd0, 0, lat);

        // Negative sum: -9 signed, 0 after ReLU.
        fill(-28'sd4096);
        feed(16'sd0, 0);
        collect("neg", 16'd0, 16'hFFF7, 0, lat);

        // Bias -3 in output LSBs: 9 - 3 = 6.
        fill(28'sd4096);
        feed(-16'sd3, 0);
        collect("bias", 16'd6, 16'd6, 0, lat);
        check("sat_clear_r", 64'(sat_r), 64'd0);
        check("sat_clear_s", 64'(sat_s), 64'd0);

        // Positive saturation, then stickiness across an in-range output.
        fill(28'sd134217727);
        feed(16'sd0, 0);
        collect("sat_pos", 16'd32767, 16'd32767, 0, lat);
        check("sat_set_r", 64'(sat_r), 64'd1);
        check("sat_set_s", 64'(sat_s), 64'd1);
        fill(28'sd4096);
        feed(16'sd0, 0);
        collect("after_sat", 16'd9, 16'd9, 0, lat);
        check("sat_sticky_r", 64'(sat_r), 64'd1);
        check("sat_sticky_s", 64'(sat_s), 64'd1);

        // Negative saturation on the signed build.
        fill(-28'sd134217728);
        feed(16'sd0, 0);
        collect("sat_neg", 16'd0, 16'h8000, 0, lat);

        // Output stall: 1000..9000 plus bias 2 -> (8192+45000+2048)>>12 = 13.
        for (int t = 0; t < 9; t++) kp[t] = 28'(1000 * (t + 1));
        out_ready = 1'b0;
        feed(16'sd2, 0);
        step();
        check("hold_valid", 64'(if_r.out_valid), 64'd1);
        // Present the next kernel's first tap while blocked; it must be taken exactly once.
        in_valid = 1'b1;
        in_prod  = 28'sd81920;
        in_bias  = 16'sd0;
        for (int i = 0; i < 5; i++) begin
            check("hold_data_r", 64'(if_r.out_data), 64'd13);
            check("hold_data_s", 64'(if_s.out_data), 64'd13);
            check("hold_in_ready", 64'(if_r.in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("hold_released", 64'(if_r.out_valid), 64'd0);
        // 20*4096 + 8*4096 = 28*4096, +0.5 rounds down to 28.
        fill(28'sd4096); kp[0] = 28'sd81920;
        feed(16'sd0, 0);
        collect("after_hold", 16'd28, 16'd28, 0, lat);

        // Seeded random kernels with input gaps and output stalls against the model.
        for (int k = 0; k < 20; k++) begin
            for (int t = 0; t < 9; t++) begin
                if (k % 5 == 4) kp[t] = 28'($urandom);
                else kp[t] = 28'(int'($urandom_range(4194304, 0)) - 2097152);
            end
            b  = 16'(int'($urandom_range(4000, 0)) - 2000);
            a  = kernel_acc(b);
            er = model(a, 1'b1, sr);
            es = model(a, 1'b0, ss);
            feed(b, 3);
            collect("rand", er, es, int'($urandom_range(3, 0)), lat);
        end

        // Reset after 4 taps discards the partial sum and clears the sticky flag.
        fill(28'sd134217727);
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            in_prod  = kp[t];
            in_bias  = 16'sd100;
            wait_ready();
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(if_r.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(if_s.out_valid), 64'd0);
        check("mid_rst_out_data", 64'(if_s.out_data), 64'd0);
        check("mid_rst_sat", 64'({sat_r, sat_s}), 64'd0);
        step();
        reset = 1'b1;
        step();
        // 5*4096 + 9*4096 = 14*4096, +0.5 -> 14.
        fill(28'sd4096);
        feed(16'sd5, 0);
        collect("post_rst", 16'd14, 16'd14, 0, lat);
        check("post_rst_sat", 64'({sat_r, sat_s}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
